// File: rtl/debounce_pkg.sv
// Shared types and constants for the pad debouncer and its synchronizer.
package debounce_pkg;

    localparam int unsigned debounce_min_stable = 2;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_PEND_HIGH,
        ST_HIGH,
        ST_PEND_LOW
    } debounce_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to RESET_VAL.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw pad into a clean level plus one-cycle rise/fall strobes.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter bit          INVERT        = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < debounce_min_stable || STABLE_CYCLES < debounce_min_stable) begin : g_param_err
        $error("button_debounce: SYNC_STAGES and STABLE_CYCLES must both be >= 2");
    end

    logic            sync_out;
    logic            s;
    debounce_state_t state;
    logic [CNT_W-1:0] cnt;

    // Reset to the idle pad value so a resting pad never looks like an edge.
    sync_ff #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(INVERT)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_in),
        .o_q    (sync_out)
    );

    assign s = sync_out ^ INVERT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_LOW;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            unique case (state)
                ST_LOW: begin
                    if (s) begin
                        state <= ST_PEND_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_PEND_HIGH: begin
                    if (!s) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_HIGH;
                        cnt     <= '0;
                        o_level <= 1'b1;
                        o_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state <= ST_PEND_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_PEND_LOW: begin
                    if (s) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_LOW;
                        cnt     <= '0;
                        o_level <= 1'b0;
                        o_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: pad-level vector tables feed a strobe scoreboard, plus reset corners.
module tb_button_debounce;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 8;
    // Edges from the next sampling edge to the strobe edge, counted from the driving negedge.
    localparam int LAT = 1 + (SYNC - 1) + STABLE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic in0   = 1'b0;
    logic in1   = 1'b1;
    logic level0, rise0, fall0;
    logic level1, rise1, fall1;

    always #5 clk = ~clk;

    button_debounce #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .INVERT       (1'b0)
    ) u_dut0 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_in   (in0),
        .o_level(level0),
        .o_rise (rise0),
        .o_fall (fall0)
    );

    button_debounce #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .INVERT       (1'b1)
    ) u_dut1 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_in   (in1),
        .o_level(level1),
        .o_rise (rise1),
        .o_fall (fall1)
    );

    // exp: 0 = no strobe, 1 = rise, 2 = fall, expected LAT edges after the pad change.
    typedef struct {
        logic       lvl;
        int         hold;
        logic [1:0] exp;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic [1:0] kind;
    } evt_t;

    vec_t vecs0[$];
    vec_t vecs1[$];
    evt_t sb[$];
    int   cyc       = 0;
    bit   mon_en    = 1'b0;
    bit   sel       = 1'b0;
    logic exp_level = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (sel) in1 = v.lvl;
        else     in0 = v.lvl;
        if (v.exp != 2'd0) sb.push_back('{cyc + LAT, v.exp});
        repeat (v.hold) @(negedge clk);
    endtask

    always @(posedge clk) begin : mon
        logic er, ef;
        cyc = cyc + 1;
        #2;
        if (mon_en) begin
            er = 1'b0;
            ef = 1'b0;
            if (sb.size() > 0 && sb[0].edge_n == cyc) begin
                er        = (sb[0].kind == 2'd1);
                ef        = (sb[0].kind == 2'd2);
                exp_level = er;
                void'(sb.pop_front());
            end
            check("rise", sel ? rise1 : rise0, er);
            check("fall", sel ? fall1 : fall0, ef);
            check("level", sel ? level1 : level0, exp_level);
        end
    end

    initial begin
        // Plain pad: idle, clean edges, bounce train, 7/8-cycle boundary pulses.
        vecs0.push_back('{1'b0, 100, 2'd0});
        vecs0.push_back('{1'b1, 50, 2'd1});
        vecs0.push_back('{1'b0, 50, 2'd2});
        for (int i = 0; i < 3; i++) begin
            vecs0.push_back('{1'b1, 5, 2'd0});
            vecs0.push_back('{1'b0, 2, 2'd0});
        end
        vecs0.push_back('{1'b1, 30, 2'd1});
        vecs0.push_back('{1'b0, 30, 2'd2});
        vecs0.push_back('{1'b1, 7, 2'd0});
        vecs0.push_back('{1'b0, 20, 2'd0});
        vecs0.push_back('{1'b1, 8, 2'd1});
        vecs0.push_back('{1'b0, 20, 2'd2});
        // Active-low pad.
        vecs1.push_back('{1'b1, 20, 2'd0});
        vecs1.push_back('{1'b0, 30, 2'd1});
        vecs1.push_back('{1'b1, 30, 2'd2});

        #1;
        check("rst_level0", level0, 1'b0);
        check("rst_rise0", rise0, 1'b0);
        check("rst_fall0", fall0, 1'b0);
        check("rst_level1", level1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (vecs0[i]) run_vec(vecs0[i]);

        // Reset while pending high with the count at 5, pad kept high through release.
        in0 = 1'b1;
        repeat (7) @(negedge clk);
        mon_en = 1'b0;
        check("pend_high_level", level0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_pend_level", level0, 1'b0);
        check("rst_pend_rise", rise0, 1'b0);
        check("rst_pend_fall", fall0, 1'b0);
        sb.delete();
        exp_level = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{cyc + LAT, 2'd1});
        mon_en = 1'b1;
        repeat (30) @(negedge clk);

        // Reset while pending low: the committed high must drop asynchronously.
        in0 = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("pend_low_level", level0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_clear_level", level0, 1'b0);
        sb.delete();
        exp_level = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // Inverted instance, pad held high (inactive) through reset.
        mon_en = 1'b0;
        sel    = 1'b1;
        in1    = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("inv_rst_level", level1, 1'b0);
        sb.delete();
        exp_level = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        foreach (vecs1[i]) run_vec(vecs1[i]);

        mon_en = 1'b0;
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
